// File: rtl/tnoc_flit_link_receiver.sv
// Receiving end of a router-to-router flit link: one FIFO per virtual channel,
// per-VC head/tail framing check, and ready / VC-availability back to the sender.
module tnoc_flit_link_receiver #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 66,
  parameter int DEPTH      = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [CHANNELS-1:0]            i_valid,
  output logic [CHANNELS-1:0]            o_ready,
  input  logic [FLIT_WIDTH-1:0]          i_flit,
  output logic [CHANNELS-1:0]            o_vc_available,
  output logic [CHANNELS-1:0]            o_valid,
  output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit,
  input  logic [CHANNELS-1:0]            i_ready,
  output logic [CHANNELS-1:0]            o_framing_error,
  output logic                           o_onehot_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AVAIL_LIMIT = PW'(DEPTH - 2);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_PACKET = 1'b1
  } frame_state_e;

  logic [CHANNELS-1:0] valid_low;
  logic                multi_valid;
  logic                onehot_error;

  // x & (x-1) is non-zero exactly when more than one bit of x is set
  assign valid_low   = i_valid - CHANNELS'(1);
  assign multi_valid = (i_valid & valid_low) != {CHANNELS{1'b0}};

  // Sticky multi-hot valid detector
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      onehot_error <= 1'b0;
    end else if (multi_valid) begin
      onehot_error <= 1'b1;
    end else begin
      onehot_error <= onehot_error;
    end
  end

  assign o_onehot_error = onehot_error;

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         count;
    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    frame_state_e          state;
    frame_state_e          state_next;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  head;
    logic                  tail;
    logic                  frame_violation;
    logic                  framing_error;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign push  = i_valid[v] && !full && !multi_valid;
    assign pop   = i_ready[v] && !empty;
    assign head  = i_flit[FLIT_WIDTH-1];
    assign tail  = i_flit[FLIT_WIDTH-2];

    // Framing decode of the flit on the bus, applied only when it is pushed
    always_comb begin
      state_next      = state;
      frame_violation = 1'b0;
      case (state)
        ST_IDLE: begin
          if (head) begin
            state_next = tail ? ST_IDLE : ST_PACKET;
          end else begin
            frame_violation = 1'b1;
          end
        end
        ST_PACKET: begin
          frame_violation = head;
          state_next      = tail ? ST_IDLE : ST_PACKET;
        end
        default: begin
          state_next      = ST_IDLE;
          frame_violation = 1'b0;
        end
      endcase
    end

    // Pointers, framing state and sticky framing error
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        wr_ptr        <= {PW{1'b0}};
        rd_ptr        <= {PW{1'b0}};
        state         <= ST_IDLE;
        framing_error <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr        <= wr_ptr + PW'(1);
          state         <= state_next;
          framing_error <= framing_error | frame_violation;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end

    // Storage needs no reset: contents are only visible while non-empty
    always_ff @(posedge i_clk) begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= i_flit;
      end
    end

    assign o_ready[v]         = !full;
    assign o_valid[v]         = !empty;
    assign o_vc_available[v]  = (state == ST_IDLE) && (count <= AVAIL_LIMIT);
    assign o_framing_error[v] = framing_error;
    assign o_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_tnoc_flit_link_receiver.sv
// Bench for tnoc_flit_link_receiver: directed vector table, hand sequences and
// random traffic, all checked against a queue-based reference model.
module tb_tnoc_flit_link_receiver;

  localparam int CH    = 2;
  localparam int FW    = 66;
  localparam int DEPTH = 4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [CH-1:0]     i_valid;
  logic [CH-1:0]     o_ready;
  logic [FW-1:0]     i_flit;
  logic [CH-1:0]     o_vc_available;
  logic [CH-1:0]     o_valid;
  logic [CH*FW-1:0]  o_flit;
  logic [CH-1:0]     i_ready;
  logic [CH-1:0]     o_framing_error;
  logic              o_onehot_error;

  tnoc_flit_link_receiver #(.CHANNELS(CH), .FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_flit(i_flit), .o_vc_available(o_vc_available), .o_valid(o_valid),
    .o_flit(o_flit), .i_ready(i_ready), .o_framing_error(o_framing_error),
    .o_onehot_error(o_onehot_error)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a queue per VC plus an "inside a packet" bit
  logic [FW-1:0] mq [CH][$];
  bit            m_pkt [CH];
  bit [CH-1:0]   m_ferr;
  bit            m_oh;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] ready;
    logic       head;
    logic       tail;
    logic [1:0] e_valid;
    logic [1:0] e_ready;
    logic [1:0] e_avail;
    logic [1:0] e_ferr;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic head, input logic tail);
    logic [63:0] pay;
    pay = {$urandom, $urandom};
    return {head, tail, pay};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < CH; v++) begin
      mq[v].delete();
      m_pkt[v] = 1'b0;
    end
    m_ferr = '0;
    m_oh   = 1'b0;
  endtask

  task automatic model_step();
    bit multi;
    multi = $countones(i_valid) > 1;
    if (multi) m_oh = 1'b1;
    for (int v = 0; v < CH; v++) begin
      int  sz;
      bit  do_pop, do_push, h, t;
      sz      = mq[v].size();
      do_pop  = (sz > 0) && i_ready[v];
      do_push = i_valid[v] && (sz < DEPTH) && !multi;
      if (do_pop) void'(mq[v].pop_front());
      if (do_push) begin
        h = i_flit[FW-1];
        t = i_flit[FW-2];
        if (!m_pkt[v] && !h) m_ferr[v] = 1'b1;
        if (m_pkt[v] && h)   m_ferr[v] = 1'b1;
        if (h || m_pkt[v])   m_pkt[v] = !t;
        mq[v].push_back(i_flit);
      end
    end
  endtask

  task automatic check_model();
    for (int v = 0; v < CH; v++) begin
      int sz;
      sz = mq[v].size();
      chk($sformatf("valid[%0d]", v), o_valid[v], sz > 0);
      if (sz > 0) chk($sformatf("flit[%0d]", v), o_flit[v*FW +: FW], mq[v][0]);
      chk($sformatf("ready[%0d]", v), o_ready[v], sz < DEPTH);
      chk($sformatf("vc_avail[%0d]", v), o_vc_available[v], !m_pkt[v] && (sz <= DEPTH - 2));
    end
    chk("framing_error", o_framing_error, m_ferr);
    chk("onehot_error", o_onehot_error, m_oh);
  endtask

  task automatic step(input logic [1:0] valid, input logic [1:0] ready, input logic [FW-1:0] flit);
    i_valid = valid;
    i_ready = ready;
    i_flit  = flit;
    model_step();
    @(posedge i_clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    i_valid = '0;
    i_ready = '0;
    i_flit  = '0;
    i_rst   = 1'b1;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_model();
  endtask

  task automatic drain(input bit rand_ready);
    for (int c = 0; c < 200 && (mq[0].size() + mq[1].size()) > 0; c++)
      step(2'b00, rand_ready ? 2'($urandom_range(0, 3)) : 2'b11, mk(1'b0, 1'b0));
    chk("drain_done", o_valid, 2'b00);
  endtask

  initial begin
    // valid, ready, head, tail -> o_valid, o_ready, o_vc_available, o_framing_error
    tbl[0]  = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 2'b11, 2'b11, 2'b00};
    tbl[1]  = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 2'b11, 2'b11, 2'b00};
    tbl[2]  = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 2'b11, 2'b01, 2'b00};
    tbl[3]  = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 2'b01, 2'b01, 2'b00};
    tbl[4]  = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 2'b01, 2'b01, 2'b00};
    tbl[5]  = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b10, 2'b11, 2'b01, 2'b00};
    tbl[6]  = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b10, 2'b11, 2'b11, 2'b00};
    tbl[7]  = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b10, 2'b11, 2'b11, 2'b00};
    tbl[8]  = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00};
    tbl[9]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b11, 2'b10, 2'b00};
    tbl[10] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b11, 2'b10, 2'b00};
    tbl[11] = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b11, 2'b10, 2'b00};
    tbl[12] = '{2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b11, 2'b00};
    tbl[13] = '{2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b11, 2'b00};
    tbl[14] = '{2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00};
    tbl[15] = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 2'b11, 2'b11, 2'b10};
    tbl[16] = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b10};
    tbl[17] = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b11, 2'b10, 2'b10};
    tbl[18] = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b11, 2'b10, 2'b11};
    tbl[19] = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b11, 2'b10, 2'b11};
    tbl[20] = '{2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b11, 2'b11};
    tbl[21] = '{2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b11, 2'b11, 2'b11};
    tbl[22] = '{2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11};

    do_reset();
    chk("rst_ready", o_ready, 2'b11);
    chk("rst_avail", o_vc_available, 2'b11);
    chk("rst_valid", o_valid, 2'b00);

    // Fill/drain VC1, then framing scenarios, from the table
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].valid, tbl[i].ready, mk(tbl[i].head, tbl[i].tail));
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_avail", i), o_vc_available, tbl[i].e_avail);
      chk($sformatf("tbl%0d_ferr", i), o_framing_error, tbl[i].e_ferr);
    end

    // Asynchronous reset mid-packet with three flits queued on VC0
    do_reset();
    step(2'b01, 2'b00, mk(1'b1, 1'b0));
    step(2'b01, 2'b00, mk(1'b0, 1'b0));
    step(2'b01, 2'b00, mk(1'b0, 1'b0));
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("async_rst_valid", o_valid, 2'b00);
    chk("async_rst_ready", o_ready, 2'b11);
    chk("async_rst_avail", o_vc_available, 2'b11);
    chk("async_rst_ferr", o_framing_error, 2'b00);
    chk("async_rst_oh", o_onehot_error, 1'b0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    step(2'b00, 2'b00, mk(1'b0, 1'b0));

    // Push and pop together at count 2 across pointer wrap
    do_reset();
    step(2'b01, 2'b00, mk(1'b1, 1'b1));
    step(2'b01, 2'b00, mk(1'b1, 1'b1));
    for (int i = 0; i < 10; i++) step(2'b01, 2'b01, mk(1'b1, 1'b1));
    chk("pp2_avail", o_vc_available[0], 1'b1);
    drain(1'b0);

    // Push and pop together while full: push refused, count drops to 3
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b01, 2'b00, mk(1'b1, 1'b1));
    step(2'b01, 2'b01, mk(1'b1, 1'b1));
    chk("pp4_ready", o_ready[0], 1'b1);
    chk("pp4_avail", o_vc_available[0], 1'b0);
    drain(1'b0);

    // Multi-hot valid
    do_reset();
    step(2'b10, 2'b00, mk(1'b1, 1'b1));
    step(2'b11, 2'b00, mk(1'b1, 1'b1));
    chk("oh_set", o_onehot_error, 1'b1);
    chk("oh_counts", o_valid, 2'b10);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, mk(1'b0, 1'b0));
    chk("oh_sticky", o_onehot_error, 1'b1);
    do_reset();
    chk("oh_cleared", o_onehot_error, 1'b0);

    // Interleaved 3-flit packets with random back-pressure
    for (int i = 0; i < 6; i++) begin
      int k;
      k = i / 2;
      step((i % 2 == 0) ? 2'b01 : 2'b10, 2'($urandom_range(0, 3)), mk(k == 0, k == 2));
    end
    drain(1'b1);
    chk("interleave_ferr", o_framing_error, 2'b00);
    chk("interleave_avail", o_vc_available, 2'b11);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] vld;
      r = $urandom_range(0, 19);
      if (r < 12)       vld = 2'b01 << $urandom_range(0, 1);
      else if (r == 19) vld = 2'b11;
      else              vld = 2'b00;
      step(vld, 2'($urandom_range(0, 3)), mk($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0));
    end
    drain(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tnoc_flit_link_receiver.md
# tnoc_flit_link_receiver

Receiving end of a router-to-router flit link. It accepts flits from the upstream router's outgoing channel into one FIFO per virtual channel, checks head/tail framing per VC, and returns ready and VC-availability back to the sender. It sits at each router input port, between the link and the router's input arbitration logic.

## Interface
- CHANNELS, default 2: number of virtual channels (1..8).
- FLIT_WIDTH, default 66: flit bits. Bit FLIT_WIDTH-1 is head, bit FLIT_WIDTH-2 is tail, the rest is payload.
- DEPTH, default 4: FIFO entries per VC, a power of 2, at least 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous and active-high.
- i_valid  in  CHANNELS  per-VC flit valid on the shared link bus; at most one bit set per cycle.
- o_ready  out  CHANNELS  per-VC ready; equals "FIFO[v] not full".
- i_flit  in  FLIT_WIDTH  shared link flit bus.
- o_vc_available  out  CHANNELS  VC v may start a new packet.
- o_valid  out  CHANNELS  per-VC FIFO not empty.
- o_flit  out  CHANNELS*FLIT_WIDTH  FIFO heads; slice v is bits [v*FLIT_WIDTH +: FLIT_WIDTH].
- i_ready  in  CHANNELS  downstream pop for each VC.
- o_framing_error  out  CHANNELS  sticky per-VC framing error.
- o_onehot_error  out  1  sticky: more than one i_valid bit seen in a cycle.

## Operation
- Push to VC v when i_valid[v] && o_ready[v] && the valid is legal. Pop from VC v when o_valid[v] && i_ready[v]. Push and pop on the same VC in the same cycle are both allowed when the FIFO is neither full nor empty.
- When the FIFO is full, o_ready[v] is 0 and no push happens, even if a pop happens in that cycle. o_ready is not recomputed combinationally from i_ready.
- Multiple i_valid bits set in one cycle:
  - No push to any VC in that cycle.
  - o_onehot_error is set to 1 and stays 1 until reset.
- Per-VC framing state machine, updated on every push:
  - IDLE:
    - head=1, tail=1 → stay in IDLE.
    - head=1, tail=0 → go to PACKET.
    - head=0 → set o_framing_error[v]; the flit is still stored; stay in IDLE.
  - PACKET:
    - head=0, tail=1 → go to IDLE.
    - head=0, tail=0 → stay in PACKET.
    - head=1 → set o_framing_error[v]; the flit is stored; the new head's tail bit selects the next state as in IDLE.
- o_vc_available[v] = (state[v]==IDLE) && (count[v] <= DEPTH-2). This guarantees room for at least a head plus one more flit.
- FIFO pointers are log2(DEPTH)+1 bits wide. Full is "MSBs differ, rest equal"; empty is "pointers equal". Pointers wrap modulo 2*DEPTH.
- count[v] = wr_ptr - rd_ptr, computed modulo 2*DEPTH, in the range 0..DEPTH.

## Timing
- On reset, and asynchronously whenever i_rst=1:
  - Pointers are 0, all states are IDLE.
  - o_valid=0, o_ready=all 1, o_vc_available=all 1.
  - o_framing_error=0, o_onehot_error=0.
  - Any in-flight packet is discarded; FIFO contents are don't-care.
- Latency: a flit pushed at edge N is visible on o_valid/o_flit after edge N (one cycle). No combinational path from i_valid/i_flit to o_valid/o_flit.
- o_ready and o_vc_available are functions of registered state only; they have no combinational dependency on i_valid or i_ready.
- o_flit slice v holds the current head entry while o_valid[v]=1. It is don't-care when o_valid[v]=0.
- Error flags assert on the clock edge that accepts the offending flit (or sees the multi-hot valid), and are visible the cycle after.

## Test plan
- **Reset:** assert i_rst mid-packet with VC0 holding 3 flits → all outputs return to reset values asynchronously. After release, o_ready=2'b11 and o_vc_available=2'b11.
- **Fill/drain (DEPTH=4):**
  - Push 4 flits on VC1 with i_ready[1]=0 → o_ready[1]=0 after the 4th push, and o_vc_available[1] is 0 from count 3.
  - Pop all 4 → payloads come out in order, and o_valid[1] drops after the 4th pop.
- **Simultaneous push/pop:**
  - At count 2, push and pop VC0 for 10 cycles → count stays 2 and data order is preserved across pointer wrap.
  - At count 4, push plus pop → push is refused and count becomes 3.
- **Framing:**
  - VC0 sequence head, body, tail → no error; state returns to IDLE and o_vc_available[0]=1.
  - VC1 body flit while IDLE → o_framing_error[1]=1 the next cycle, and the flit is still delivered.
  - Head, head on VC0 → o_framing_error[0]=1.
- **One-hot violation:** i_valid=2'b11 for one cycle → neither FIFO count changes, and o_onehot_error=1 until reset.
- **Interleaved VCs:** alternate VC0/VC1 flits of two 3-flit packets with random i_ready back-pressure → each VC's output matches its input order and no error flags are set.
